// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache request streams, the arbiter and the single RAM port.
// The arbiter uses the slave modport; caches and RAM together form the master side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache. dcache wins contention, but after
// MAX_DSTREAK dcache completions with icache waiting, icache is forced a grant.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    localparam int unsigned StreakW = $clog2(MAX_DSTREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIserv = 2'd1,
        StDserv = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [StreakW-1:0] streak_q, streak_d;

    logic              dreq;
    logic              iwait_c, dwait_c, ren_c, wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] store_c;

    assign dreq = bus.dREN | bus.dWEN;

    always_comb begin
        state_d = state_q;
        iwait_c = 1'b1;
        dwait_c = 1'b1;
        ren_c   = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        store_c = '0;
        unique case (state_q)
            StIdle: begin
                if (streak_q == StreakMax && bus.iREN) begin
                    state_d = StIserv;
                end else if (dreq) begin
                    state_d = StDserv;
                end else if (bus.iREN) begin
                    state_d = StIserv;
                end
            end
            StIserv: begin
                // A dropped request is a fetch flush: abort with strobes low
                if (!bus.iREN) begin
                    state_d = StIdle;
                end else begin
                    ren_c  = 1'b1;
                    addr_c = bus.iaddr;
                    if (bus.ram_ready) begin
                        iwait_c = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StDserv: begin
                if (!dreq) begin
                    state_d = StIdle;
                end else begin
                    wen_c   = bus.dWEN;
                    ren_c   = bus.dREN & ~bus.dWEN;
                    addr_c  = bus.daddr;
                    store_c = bus.dstore;
                    if (bus.ram_ready) begin
                        dwait_c = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        streak_d = streak_q;
        if (!bus.iREN) begin
            streak_d = '0;
        end else if (state_q == StIdle && state_d == StIserv) begin
            streak_d = '0;
        end else if (!dwait_c && streak_q != StreakMax) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.ramREN   = ren_c;
    assign bus.ramWEN   = wen_c;
    assign bus.ramaddr  = addr_c;
    assign bus.ramstore = store_c;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a scoreboard queue of expected completions is filled as requests
// are driven and drained by a monitor that checks every iwait/dwait completion pulse.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    localparam logic [31:0] Key = 32'hCAFE_0000;
    // RAM model: read data is a keyed function of the address currently presented
    assign bus.ramload = bus.ramaddr ^ Key;

    typedef struct {
        bit          is_i;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] store;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input bit is_i, input logic [31:0] addr, input bit wen,
                            input logic [31:0] store);
        exp_t e;
        e.is_i  = is_i;
        e.addr  = addr;
        e.wen   = wen;
        e.store = store;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (nRST && (!bus.iwait || !bus.dwait)) begin
                done_cnt++;
                checks++;
                if (!bus.iwait && !bus.dwait) begin
                    errors++;
                    $display("FAIL both_wait_low: iwait=%b dwait=%b, required only one low",
                             bus.iwait, bus.dwait);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_completion: iwait=%b dwait=%b, required both 1",
                             bus.iwait, bus.dwait);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ((!bus.iwait) !== e.is_i) begin
                        errors++;
                        $display("FAIL grant_order: icache_done=%b, required %b", !bus.iwait,
                                 e.is_i);
                    end
                    checks++;
                    if (bus.ramaddr !== e.addr) begin
                        errors++;
                        $display("FAIL ramaddr: got %h, required %h", bus.ramaddr, e.addr);
                    end
                    checks++;
                    if (e.is_i) begin
                        if (bus.iload !== (e.addr ^ Key) || bus.ramREN !== 1'b1 ||
                            bus.ramWEN !== 1'b0) begin
                            errors++;
                            $display("FAIL ifetch: iload=%h ren=%b wen=%b, required %h 1 0",
                                     bus.iload, bus.ramREN, bus.ramWEN, e.addr ^ Key);
                        end
                    end else if (e.wen) begin
                        if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 ||
                            bus.ramstore !== e.store) begin
                            errors++;
                            $display("FAIL dwrite: wen=%b ren=%b store=%h, required 1 0 %h",
                                     bus.ramWEN, bus.ramREN, bus.ramstore, e.store);
                        end
                    end else begin
                        if (bus.dload !== (e.addr ^ Key) || bus.ramREN !== 1'b1 ||
                            bus.ramWEN !== 1'b0) begin
                            errors++;
                            $display("FAIL dread: dload=%h ren=%b wen=%b, required %h 1 0",
                                     bus.dload, bus.ramREN, bus.ramWEN, e.addr ^ Key);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL completion_timeout: completions=%0d, required %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.ramREN !== 1'b0 ||
            bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: iw=%b dw=%b ren=%b wen=%b addr=%h st=%h, required 1 1 0 0 0 0",
                     bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_access();
        int base = done_cnt;
        bus.iaddr = 32'h4C;
        bus.iREN = 1'b1;
        bus.daddr = 32'h90;
        bus.dstore = 32'h1234_5678;
        bus.dWEN = 1'b1;
        bus.ram_ready = 1'b1;
        push_exp(1'b0, 32'h90, 1'b1, 32'h1234_5678);
        wait_done(base + 1, 6);
        bus.ram_ready = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (bus.ramWEN !== 1'b1 || dut.streak_q !== 3'd1) begin
            errors++;
            $display("FAIL second_dserv: wen=%b streak=%0d, required 1 1", bus.ramWEN,
                     dut.streak_q);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1 || bus.ramREN !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: wen=%b dwait=%b ren=%b, required 0 1 0", bus.ramWEN,
                     bus.dwait, bus.ramREN);
        end
        bus.dWEN = 1'b0;
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (dut.state_q !== 2'd0 || dut.streak_q !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_state: state=%0d streak=%0d, required 0 0", dut.state_q,
                     dut.streak_q);
        end
        bus.iREN = 1'b0;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_leftover: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_ifetch();
        int base = done_cnt;
        bus.iaddr = 32'h40;
        bus.iREN = 1'b1;
        bus.ram_ready = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL iserv_strobe: ren=%b addr=%h iwait=%b, required 1 00000040 1",
                     bus.ramREN, bus.ramaddr, bus.iwait);
        end
        tick();
        bus.ram_ready = 1'b1;
        push_exp(1'b1, 32'h40, 1'b0, 32'h0);
        wait_done(base + 1, 5);
        bus.iREN = 1'b0;
        bus.ram_ready = 1'b0;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ifetch_leftover: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        int base = done_cnt;
        bus.iaddr = 32'h44;
        bus.daddr = 32'h84;
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.ram_ready = 1'b1;
        push_exp(1'b0, 32'h84, 1'b0, 32'h0);
        push_exp(1'b1, 32'h44, 1'b0, 32'h0);
        wait_done(base + 1, 6);
        bus.dREN = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL dead_cycle: ren=%b wen=%b iwait=%b, required 0 0 1", bus.ramREN,
                     bus.ramWEN, bus.iwait);
        end
        wait_done(base + 2, 6);
        bus.iREN = 1'b0;
        bus.ram_ready = 1'b0;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL contention_leftover: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_streak();
        int base = done_cnt;
        bus.iaddr = 32'h48;
        bus.daddr = 32'h88;
        for (int k = 0; k < 4; k++) push_exp(1'b0, 32'h88, 1'b0, 32'h0);
        push_exp(1'b1, 32'h48, 1'b0, 32'h0);
        push_exp(1'b0, 32'h88, 1'b0, 32'h0);
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.ram_ready = 1'b1;
        wait_done(base + 4, 12);
        checks++;
        if (dut.streak_q !== 3'd4) begin
            errors++;
            $display("FAIL streak_saturate: streak=%0d, required 4", dut.streak_q);
        end
        wait_done(base + 5, 6);
        checks++;
        if (dut.streak_q !== 3'd0) begin
            errors++;
            $display("FAIL streak_clear: streak=%0d, required 0", dut.streak_q);
        end
        wait_done(base + 6, 6);
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.ram_ready = 1'b0;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL streak_leftover: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_write();
        int base = done_cnt;
        bus.daddr = 32'h80;
        bus.dstore = 32'hDEAD_BEEF;
        bus.dREN = 1'b1;
        bus.dWEN = 1'b1;
        bus.ram_ready = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'hDEAD_BEEF ||
            bus.ramaddr !== 32'h80) begin
            errors++;
            $display("FAIL write_strobes: wen=%b ren=%b st=%h addr=%h, required 1 0 deadbeef 00000080",
                     bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
        end
        tick();
        bus.ram_ready = 1'b1;
        push_exp(1'b0, 32'h80, 1'b1, 32'hDEAD_BEEF);
        wait_done(base + 1, 5);
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.ram_ready = 1'b0;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL write_leftover: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        int base = done_cnt;
        bus.iaddr = 32'h100;
        bus.iREN = 1'b1;
        bus.ram_ready = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b1) begin
            errors++;
            $display("FAIL flush_grant: ren=%b, required 1", bus.ramREN);
        end
        tick();
        bus.iREN = 1'b0;
        bus.ram_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL flush_abort: ren=%b wen=%b iwait=%b, required 0 0 1", bus.ramREN,
                     bus.ramWEN, bus.iwait);
        end
        tick();
        bus.ram_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (dut.state_q !== 2'd0 || done_cnt != base) begin
            errors++;
            $display("FAIL flush_idle: state=%0d completions=%0d, required 0 %0d", dut.state_q,
                     done_cnt, base);
        end
        tick();
    endtask

    initial begin
        bus.iREN = 1'b0;
        bus.iaddr = '0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.daddr = '0;
        bus.dstore = '0;
        bus.ram_ready = 1'b0;
        fork
            monitor();
        join_none
        #1;
        test_reset();
        test_reset_mid_access();
        test_ifetch();
        test_contention();
        test_streak();
        test_write();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
